inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/if_id.sv | 25 ++
 rtl/inst_fetch.sv | 89 ++++++++
 tb/tb_inst_fetch.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared CPU defines for the fetch stage: widths, reset PC, NOP encoding
// and the IF/ID payload type.
package inst_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP      = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              valid;
  } if_id_t;

  // Instruction addresses are always word aligned; low target bits are dropped.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/if_id.sv
// IF/ID pipeline register: one-cycle fetch-to-decode latency.
// Flush beats decode stall; a fetch stall alone inserts a bubble.
module if_id
  import inst_fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   stall_id,
  input  logic   stall_if,
  input  if_id_t fetch,
  output if_id_t id
);

  localparam if_id_t BUBBLE = '{pc: '0, inst: NOP, valid: 1'b0};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id <= BUBBLE;
    end else if (!stall_id) begin
      id <= stall_if ? BUBBLE : fetch;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC sequencing with delay-slot branches, branch capture under
// stall, flush redirect, and the IF/ID register feeding decode.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if_i,
  input  logic              stall_id_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  input  logic [INST_W-1:0] inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o
);

  logic              ce;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              pend;
  logic              pend_next;
  logic [ADDR_W-1:0] pend_tgt;
  logic [ADDR_W-1:0] pend_tgt_next;
  if_id_t            fetch;
  if_id_t            id;

  always_comb begin
    pc_next       = pc;
    pend_next     = pend;
    pend_tgt_next = pend_tgt;
    if (!ce) begin
      pc_next = RESET_PC;
    end else if (flush_i) begin
      pc_next   = word_align(new_pc_i);
      pend_next = 1'b0;
    end else if (stall_if_i) begin
      // A branch resolved while fetch is frozen must not be lost.
      if (branch_flag_i) begin
        pend_next     = 1'b1;
        pend_tgt_next = word_align(branch_target_i);
      end
    end else if (pend) begin
      pc_next   = pend_tgt;
      pend_next = 1'b0;
    end else if (branch_flag_i) begin
      pc_next = word_align(branch_target_i);
    end else begin
      pc_next = pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce       <= 1'b0;
      pc       <= RESET_PC;
      pend     <= 1'b0;
      pend_tgt <= '0;
    end else begin
      ce       <= 1'b1;
      pc       <= pc_next;
      pend     <= pend_next;
      pend_tgt <= pend_tgt_next;
    end
  end

  assign fetch = '{pc: pc, inst: inst_i, valid: ce};

  if_id u_if_id (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush_i),
    .stall_id (stall_id_i),
    .stall_if (stall_if_i),
    .fetch    (fetch),
    .id       (id)
  );

  assign pc_o       = pc;
  assign ce_o       = ce;
  assign id_pc_o    = id.pc;
  assign id_inst_o  = id.inst;
  assign id_valid_o = id.valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: expected post-edge state is queued with
// each stimulus cycle and compared one edge later.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if;
  logic        stall_id;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] pc;
  logic        ce;
  logic [31:0] inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Zero-latency instruction memory; contents are a fixed function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  always_comb inst = mem_word(pc);

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall_if_i      (stall_if),
    .stall_id_i      (stall_id),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .flush_i         (flush),
    .new_pc_i        (new_pc),
    .pc_o            (pc),
    .ce_o            (ce),
    .inst_i          (inst),
    .id_pc_o         (id_pc),
    .id_inst_o       (id_inst),
    .id_valid_o      (id_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_state(input string tag, input logic ce_e, input logic [31:0] pc_e,
                              input logic [31:0] ipc, input logic [31:0] iinst,
                              input logic iv);
    push({tag, ".ce"},       1, {31'b0, ce_e});
    push({tag, ".pc"},       0, pc_e);
    push({tag, ".id_pc"},    2, ipc);
    push({tag, ".id_inst"},  3, iinst);
    push({tag, ".id_valid"}, 4, {31'b0, iv});
  endtask

  // Normal fetch: ID receives the word fetched at prev_pc.
  task automatic expect_run(input string tag, input logic [31:0] pc_e, input logic [31:0] prev_pc);
    expect_state(tag, 1'b1, pc_e, prev_pc, mem_word(prev_pc), 1'b1);
  endtask

  task automatic expect_bubble(input string tag, input logic [31:0] pc_e);
    expect_state(tag, 1'b1, pc_e, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    exp_t        e;
    logic [31:0] act;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       act = pc;
        1:       act = {31'b0, ce};
        2:       act = id_pc;
        3:       act = id_inst;
        default: act = {31'b0, id_valid};
      endcase
      chk(e.tag, act, e.val);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; branch_flag = 1'b0;
    branch_target = '0; flush = 1'b0; new_pc = '0;

    expect_state("rst0", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0); tick();
    expect_state("rst1", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0); tick();

    // Reset release: ce rises, first fetch at 0, ID valid from the next edge.
    rst = 1'b0;
    expect_state("rel0", 1'b1, 32'h0, 32'h0, mem_word(32'h0), 1'b0); tick();
    expect_run("rel4", 32'h4, 32'h0); tick();
    expect_run("rel8", 32'h8, 32'h4); tick();
    expect_run("relC", 32'hC, 32'h8); tick();
    expect_run("rel10", 32'h10, 32'hC); tick();

    // Taken branch at pc=0x10; low target bits must be ignored.
    branch_flag = 1'b1; branch_target = 32'h43;
    expect_run("br_tgt", 32'h40, 32'h10); tick();
    branch_flag = 1'b0;
    expect_run("br_seq", 32'h44, 32'h40); tick();

    // Branch pulse inside a 3-cycle fetch stall.
    stall_if = 1'b1;
    expect_bubble("bs_s1", 32'h44); tick();
    branch_flag = 1'b1; branch_target = 32'h80;
    expect_bubble("bs_s2", 32'h44); tick();
    branch_flag = 1'b0; branch_target = 32'h0;
    expect_bubble("bs_s3", 32'h44); tick();
    stall_if = 1'b0;
    expect_run("bs_rel", 32'h80, 32'h44); tick();
    expect_run("bs_seq", 32'h84, 32'h80); tick();

    // Decode stall holds ID even though the fetch stall would bubble it.
    stall_if = 1'b1; stall_id = 1'b1;
    expect_run("sid_1", 32'h84, 32'h80); tick();
    expect_run("sid_2", 32'h84, 32'h80); tick();
    stall_if = 1'b0; stall_id = 1'b0;
    expect_run("sid_rel", 32'h88, 32'h84); tick();
    stall_if = 1'b1;
    expect_bubble("sif_bub", 32'h88); tick();
    stall_if = 1'b0;
    expect_run("sif_rel", 32'h8C, 32'h88); tick();

    // Flush with a pending branch, stall and a new branch all present.
    stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
    expect_bubble("fl_pend", 32'h8C); tick();
    flush = 1'b1; new_pc = 32'h181; branch_target = 32'h300;
    expect_bubble("fl_go", 32'h180); tick();
    flush = 1'b0; stall_if = 1'b0; branch_flag = 1'b0; new_pc = 32'h0;
    expect_run("fl_seq1", 32'h184, 32'h180); tick();
    expect_run("fl_seq2", 32'h188, 32'h184); tick();

    // Wrap from the top of the address space.
    branch_flag = 1'b1; branch_target = 32'hFFFF_FFFF;
    expect_run("wr_top", 32'hFFFF_FFFC, 32'h188); tick();
    branch_flag = 1'b0;
    expect_run("wr_zero", 32'h0, 32'hFFFF_FFFC); tick();
    expect_run("wr_four", 32'h4, 32'h0); tick();

    // Reset mid-stall with a pending branch and a flush request.
    stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h500;
    expect_bubble("mr_pend", 32'h4); tick();
    rst = 1'b1; flush = 1'b1; new_pc = 32'h600;
    expect_state("mr_rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0); tick();
    rst = 1'b0; flush = 1'b0; stall_if = 1'b0; branch_flag = 1'b0;
    expect_state("mr_rel", 1'b1, 32'h0, 32'h0, mem_word(32'h0), 1'b0); tick();
    expect_run("mr_nopend", 32'h4, 32'h0); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
